// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 status codes and status-controller FSM encodings
package y86_pkg;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [2:0] STAT_TMO = 3'd5;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;
endpackage

// File: rtl/y86_stat_encode.sv
// y86_stat_encode: strict-priority encoder from fault flags to the Y86 status code
module y86_stat_encode
  import y86_pkg::*;
(
  input  logic       imem_error,
  input  logic       instr_invalid,
  input  logic       hlt,
  input  logic       dmem_error,
  output logic [2:0] stat
);
  always_comb stat = imem_error    ? STAT_ADR :
                     instr_invalid ? STAT_INS :
                     hlt           ? STAT_HLT :
                     dmem_error    ? STAT_ADR : STAT_AOK;
endmodule

// File: rtl/y86_status_ctrl.sv
// y86_status_ctrl: sticky Y86 run/stop controller with commit gating and cycle/instr counters.
// Define Y86_WATCHDOG_EN to stop with TMO after MAX_CYC cycles in RUN.
module y86_status_ctrl
  import y86_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int CNT_W   = 32,
  parameter int MAX_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid_in,
  input  logic             imem_error,
  input  logic             instr_invalid,
  input  logic             hlt,
  input  logic             dmem_error,
  input  logic [PC_W-1:0]  pc_in,
  output logic             commit_en,
  output logic [2:0]       stat,
  output logic             stopped,
  output logic [PC_W-1:0]  fault_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t state, state_nx;
  logic [2:0] enc;
  logic run, fault, timeout;
  if (MAX_CYC < 2) begin : g_bad_max_cyc
    $error("MAX_CYC must be at least 2");
  end
  y86_stat_encode u_enc (
    .imem_error    (imem_error),
    .instr_invalid (instr_invalid),
    .hlt           (hlt),
    .dmem_error    (dmem_error),
    .stat          (enc)
  );
  assign run     = state == ST_RUN;
  assign fault   = run & valid_in & (enc != STAT_AOK);
  assign stopped = state == ST_STOP;
`ifdef Y86_WATCHDOG_EN
  assign timeout = run & ~fault & (cycle_cnt == CNT_W'(MAX_CYC - 1));
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx  = state;
    commit_en = run & valid_in & (enc == STAT_AOK);
    if (state == ST_IDLE && start) state_nx = ST_RUN;
    if (fault || timeout) state_nx = ST_STOP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stat      <= STAT_AOK;
      fault_pc  <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (fault || timeout) begin
        stat     <= fault ? enc : STAT_TMO;
        fault_pc <= pc_in;
      end
      if (run && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      if (commit_en && instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_y86_status_ctrl.sv
// tb_y86_status_ctrl: directed checks of y86_status_ctrl (reset, commits, fault priority, stickiness, watchdog)
module tb_y86_status_ctrl;
  logic        clk = 0, rst_n, start, valid_in, imem_error, instr_invalid, hlt, dmem_error;
  logic [63:0] pc_in, fault_pc;
  logic        commit_en, stopped;
  logic [2:0]  stat;
  logic [31:0] cycle_cnt, instr_cnt;
  int          passed = 0, total = 0;

  y86_status_ctrl #(.PC_W(64), .CNT_W(32), .MAX_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
    .imem_error(imem_error), .instr_invalid(instr_invalid), .hlt(hlt), .dmem_error(dmem_error),
    .pc_in(pc_in), .commit_en(commit_en), .stat(stat), .stopped(stopped),
    .fault_pc(fault_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; valid_in = 0; imem_error = 0; instr_invalid = 0; hlt = 0; dmem_error = 0; pc_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    check("rst_stat", stat, 1);
    check("rst_stopped", stopped, 0);
    check("rst_commit", commit_en, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_instr", instr_cnt, 0);
    check("rst_fpc", fault_pc, 0);
    valid_in = 1;
    #1 check("idle_commit", commit_en, 0);
    tick();
    check("idle_cycle", cycle_cnt, 0);
    // start with valid_in in IDLE: the valid is dropped
    start = 1;
    #1 check("start_valid_commit", commit_en, 0);
    tick();
    start = 0; valid_in = 0;
    check("start_instr", instr_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      valid_in = 1; pc_in = 64'(i * 4);
      #1 check("aok_commit", commit_en, 1);
      tick();
    end
    valid_in = 0;
    check("aok_instr", instr_cnt, 5);
    check("aok_cycle", cycle_cnt, 5);
    #1 check("bubble_commit", commit_en, 0);
    tick();
    check("bubble_cycle", cycle_cnt, 6);
    check("bubble_instr", instr_cnt, 5);
    check("bubble_stat", stat, 1);
    check("bubble_stopped", stopped, 0);
    valid_in = 1; hlt = 1; dmem_error = 1; pc_in = 64'h40;
    #1 check("hlt_commit", commit_en, 0);
    check("hlt_stopped_early", stopped, 0);
    tick();
    idle_in();
    check("hlt_stat", stat, 2);
    check("hlt_stopped", stopped, 1);
    check("hlt_fpc", fault_pc, 64'h40);
    check("hlt_instr", instr_cnt, 5);
    check("hlt_cycle", cycle_cnt, 7);
    valid_in = 1; start = 1; imem_error = 1; pc_in = 64'h99;
    #1 check("stop_commit", commit_en, 0);
    tick(); tick();
    valid_in = 0; imem_error = 0; pc_in = 64'h98;
    #1 check("stop_commit_aok", commit_en, 0);
    tick();
    idle_in();
    check("stop_stat", stat, 2);
    check("stop_fpc", fault_pc, 64'h40);
    check("stop_cycle", cycle_cnt, 7);
    check("stop_stopped", stopped, 1);
    do_reset();
    check("rst2_stat", stat, 1);
    check("rst2_stopped", stopped, 0);
    check("rst2_cycle", cycle_cnt, 0);
    check("rst2_instr", instr_cnt, 0);
    check("rst2_fpc", fault_pc, 0);
    do_start();
    valid_in = 1; imem_error = 1; instr_invalid = 1; pc_in = 64'h80;
    #1 check("adr_commit", commit_en, 0);
    tick();
    idle_in();
    check("adr_stat", stat, 3);
    check("adr_fpc", fault_pc, 64'h80);
    check("adr_cycle", cycle_cnt, 1);
    do_reset();
    do_start();
    valid_in = 1; instr_invalid = 1; hlt = 1; pc_in = 64'h10;
    tick();
    idle_in();
    check("ins_stat", stat, 4);
    check("ins_fpc", fault_pc, 64'h10);
    do_reset();
    do_start();
    valid_in = 1; dmem_error = 1; pc_in = 64'h18;
    tick();
    idle_in();
    check("dmem_stat", stat, 3);
    check("dmem_stopped", stopped, 1);
    // reset mid-RUN clears everything
    do_reset();
    do_start();
    valid_in = 1; tick(); tick(); valid_in = 0;
    do_reset();
    check("midrun_cycle", cycle_cnt, 0);
    check("midrun_instr", instr_cnt, 0);
    valid_in = 1;
    #1 check("midrun_commit", commit_en, 0);
    idle_in();
    do_start();
    valid_in = 1; pc_in = 64'h200;
    for (int c = 0; c < 20 && !stopped; c++) tick();
    idle_in();
`ifdef Y86_WATCHDOG_EN
    check("wd_stopped", stopped, 1);
    check("wd_stat", stat, 5);
    check("wd_cycle", cycle_cnt, 8);
    check("wd_fpc", fault_pc, 64'h200);
`else
    check("nowd_stopped", stopped, 0);
    check("nowd_stat", stat, 1);
    check("nowd_cycle", cycle_cnt, 20);
    check("nowd_instr", instr_cnt, 20);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
